count_gate_ctrl: RTL and testbench

- Gated event counter controller for the counting system.
- Synchronises an asynchronous event input and detects its rising edges.
- Counts edges over a programmable gate window of clk cycles, then presents the result on a valid/ready handshake.
- Sits between the event pins and the result/readout logic. Sequences the synchroniser registers, gate timer and result register.

---
 rtl/count_pkg.sv | 14 +
 rtl/async_bit_reg.sv | 17 +
 rtl/count_gate_ctrl_edge_sync.sv | 37 +++
 rtl/count_gate_ctrl.sv | 118 +++++++++++
 tb/tb_count_gate_ctrl.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/count_pkg.sv
// Shared types and default widths for the gated event counter.
package count_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArm   = 2'd1,
    StCount = 2'd2,
    StHold  = 2'd3
  } t_gate_state;

  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned GATE_W_DEF = 16;

endpackage

// File: rtl/async_bit_reg.sv
// Single-bit register cell with asynchronous active-high reset to zero.
module async_bit_reg (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_o <= 1'b0;
    end else begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/count_gate_ctrl_edge_sync.sv
// Two-flop synchroniser for an asynchronous input plus a history flop;
// emits a one-cycle pulse on each synchronised rising edge.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic edge_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  async_bit_reg u_meta (
    .clk (clk),
    .rst (rst),
    .d_i (async_i),
    .q_o (meta_q)
  );

  async_bit_reg u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (meta_q),
    .q_o (sync_q)
  );

  async_bit_reg u_prev (
    .clk (clk),
    .rst (rst),
    .d_i (sync_q),
    .q_o (prev_q)
  );

  assign edge_o = sync_q & ~prev_q;

endmodule

// File: rtl/count_gate_ctrl.sv
// Gated event counter: counts synchronised ev_in rising edges over a programmable
// window of clk cycles and offers the count on a valid/ready handshake.
module count_gate_ctrl
  import count_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned GATE_W = GATE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [GATE_W-1:0] gate_len_i,
  input  logic              ev_in_i,
  output logic              busy_o,
  output logic [CNT_W-1:0]  result_o,
  output logic              overflow_o,
  output logic              valid_o,
  input  logic              ready_i
);

  localparam logic [CNT_W-1:0]  CntMax  = {CNT_W{1'b1}};
  localparam logic [GATE_W-1:0] TimerOne = GATE_W'(1);

  t_gate_state       state_q, state_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [GATE_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sat_q, sat_d;
  logic [CNT_W-1:0]  result_q, result_d;
  logic              overflow_q, overflow_d;
  logic              ev_edge;

  edge_sync u_edge_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (ev_in_i),
    .edge_o  (ev_edge)
  );

  always_comb begin
    state_d    = state_q;
    gate_d     = gate_q;
    timer_d    = timer_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    result_d   = result_q;
    overflow_d = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          gate_d  = gate_len_i;
          state_d = StArm;
        end
      end
      StArm: begin
        cnt_d   = '0;
        sat_d   = 1'b0;
        timer_d = gate_q;
        if (gate_q == '0) begin
          result_d   = '0;
          overflow_d = 1'b0;
          state_d    = StHold;
        end else begin
          state_d = StCount;
        end
      end
      StCount: begin
        // Saturate at all-ones; the sticky flag records the lost edges.
        if (ev_edge) begin
          if (cnt_q == CntMax) begin
            sat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        timer_d = timer_q - 1'b1;
        if (timer_q == TimerOne) begin
          result_d   = cnt_d;
          overflow_d = sat_d;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      gate_q     <= '0;
      timer_q    <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_q     <= gate_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign valid_o    = (state_q == StHold);
  assign result_o   = result_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_count_gate_ctrl.sv
// Directed bench for count_gate_ctrl: a 16-bit instance plus a 4-bit instance
// sharing the same stimulus (the narrow one exercises saturation).
module tb_count_gate_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] gate_len;
  logic        ev_in;
  logic        ready;

  logic        busy, overflow, valid;
  logic [15:0] result;
  logic        busy4, overflow4, valid4;
  logic [3:0]  result4;

  int tests_run;
  int tests_failed;

  count_gate_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .gate_len_i (gate_len),
    .ev_in_i    (ev_in),
    .busy_o     (busy),
    .result_o   (result),
    .overflow_o (overflow),
    .valid_o    (valid),
    .ready_i    (ready)
  );

  count_gate_ctrl #(.CNT_W(4), .GATE_W(16)) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .gate_len_i (gate_len),
    .ev_in_i    (ev_in),
    .busy_o     (busy4),
    .result_o   (result4),
    .overflow_o (overflow4),
    .valid_o    (valid4),
    .ready_i    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Moves to the next cycle; inputs set afterwards are sampled at its end.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    ev_in = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic test_reset();
    #12;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests_run++;
    if (valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b want 0", valid); end
    tests_run++;
    if (result !== 16'd0) begin tests_failed++; $display("FAIL rst_result: got %0d want 0", result); end
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    next_cycle();
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
  endtask

  // Rises at cycles 0, 8, 16 -> edges in COUNT cycles 2, 10, 18 -> 3.
  task automatic test_basic_count();
    settle(4);
    for (int c = 0; c <= 22; c++) begin
      ev_in    = ((c / 4) % 2 == 0);
      start    = (c == 0);
      gate_len = (c == 0) ? 16'd20 : 16'hffff;
      if (c == 21) begin
        tests_run++;
        if (valid !== 1'b0) begin tests_failed++; $display("FAIL basic_early_valid: got %b want 0", valid); end
      end
      if (c == 22) begin
        tests_run++;
        if (valid !== 1'b1) begin tests_failed++; $display("FAIL basic_valid: got %b want 1", valid); end
        tests_run++;
        if (result !== 16'd3) begin tests_failed++; $display("FAIL basic_result: got %0d want 3", result); end
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL basic_ovf: got %b want 0", overflow); end
        tests_run++;
        if (result4 !== 4'd3) begin tests_failed++; $display("FAIL basic_result4: got %0d want 3", result4); end
        ready = 1'b1;
      end
      next_cycle();
    end
    ready = 1'b0;
    tests_run++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_release: got valid=%b busy=%b want 0 0", valid, busy);
    end
    tests_run++;
    if (result !== 16'd3) begin tests_failed++; $display("FAIL basic_retain: got %0d want 3", result); end
  endtask

  task automatic test_reset_mid_count();
    settle(4);
    for (int c = 0; c < 12; c++) begin
      ev_in    = (c < 10) && ((c / 2) % 2 == 0);
      start    = (c == 0);
      gate_len = 16'd50;
      next_cycle();
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    tests_run++;
    if (valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_valid: got %b want 0", valid); end
    tests_run++;
    if (result !== 16'd0) begin tests_failed++; $display("FAIL mid_rst_result: got %0d want 0", result); end
    next_cycle();
    rst = 1'b0;
    settle(3);
    for (int c = 0; c <= 12; c++) begin
      start    = (c == 0);
      gate_len = 16'd10;
      if (c == 12) begin
        tests_run++;
        if (valid !== 1'b1) begin tests_failed++; $display("FAIL post_rst_valid: got %b want 1", valid); end
        tests_run++;
        if (result !== 16'd0) begin tests_failed++; $display("FAIL post_rst_result: got %0d want 0", result); end
        ready = 1'b1;
      end
      next_cycle();
    end
    ready = 1'b0;
  endtask

  // Rises every 4 cycles from 0; edges at 2..98 in COUNT window 2..101 -> 25.
  task automatic test_saturation();
    settle(4);
    for (int c = 0; c <= 102; c++) begin
      ev_in    = ((c / 2) % 2 == 0);
      start    = (c == 0);
      gate_len = 16'd100;
      if (c == 102) begin
        tests_run++;
        if (valid4 !== 1'b1) begin tests_failed++; $display("FAIL sat_valid: got %b want 1", valid4); end
        tests_run++;
        if (result4 !== 4'd15) begin tests_failed++; $display("FAIL sat_result: got %0d want 15", result4); end
        tests_run++;
        if (overflow4 !== 1'b1) begin tests_failed++; $display("FAIL sat_ovf: got %b want 1", overflow4); end
        tests_run++;
        if (result !== 16'd25) begin tests_failed++; $display("FAIL wide_result: got %0d want 25", result); end
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL wide_ovf: got %b want 0", overflow); end
        ready = 1'b1;
      end
      next_cycle();
    end
    ready = 1'b0;
  endtask

  task automatic test_zero_gate();
    settle(4);
    start    = 1'b1;
    gate_len = 16'd0;
    next_cycle();
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_arm: got busy=%b valid=%b want 1 0", busy, valid);
    end
    next_cycle();
    tests_run++;
    if (valid !== 1'b1) begin tests_failed++; $display("FAIL zero_valid: got %b want 1", valid); end
    tests_run++;
    if (result !== 16'd0) begin tests_failed++; $display("FAIL zero_result: got %0d want 0", result); end
    tests_run++;
    if (overflow4 !== 1'b0 || result4 !== 4'd0) begin
      tests_failed++;
      $display("FAIL zero_sat_clear: got ovf=%b res=%0d want 0 0", overflow4, result4);
    end
    ready = 1'b1;
    next_cycle();
    ready = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_idle: got busy=%b valid=%b want 0 0", busy, valid);
    end
  endtask

  // Rise at cycle 1 -> edge at cycle 3 inside COUNT 2..4 -> result 1, valid at 5.
  task automatic test_backpressure();
    settle(4);
    for (int c = 0; c <= 12; c++) begin
      ev_in    = (c >= 1);
      start    = (c == 0) || (c == 7) || (c == 9) || (c == 12);
      gate_len = (c == 0) ? 16'd3 : 16'd0;
      ready    = (c == 12);
      if (c >= 5 && c <= 11) begin
        tests_run++;
        if (valid !== 1'b1 || busy !== 1'b1 || result !== 16'd1) begin
          tests_failed++;
          $display("FAIL bp_hold c=%0d: got valid=%b busy=%b res=%0d want 1 1 1",
                   c, valid, busy, result);
        end
      end
      next_cycle();
    end
    start = 1'b0;
    ready = 1'b0;
    ev_in = 1'b0;
    tests_run++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: got valid=%b busy=%b want 0 0", valid, busy);
    end
    next_cycle();
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL bp_no_queue: got busy=%b want 0", busy); end
    tests_run++;
    if (result !== 16'd1) begin tests_failed++; $display("FAIL bp_retain: got %0d want 1", result); end
    for (int c = 0; c <= 4; c++) begin
      start    = (c == 0);
      gate_len = 16'd2;
      if (c == 4) begin
        tests_run++;
        if (valid !== 1'b1 || result !== 16'd0) begin
          tests_failed++;
          $display("FAIL bp_rerun: got valid=%b res=%0d want 1 0", valid, result);
        end
        ready = 1'b1;
      end
      next_cycle();
    end
    ready = 1'b0;
  endtask

  // gate 5: COUNT cycles 2..6; rise at cycle r gives edge at r+2.
  task automatic boundary_run(input int r, input logic [15:0] exp);
    settle(4);
    for (int c = 0; c <= 7; c++) begin
      ev_in    = (c >= r);
      start    = (c == 0);
      gate_len = 16'd5;
      if (c == 7) begin
        tests_run++;
        if (valid !== 1'b1 || result !== exp) begin
          tests_failed++;
          $display("FAIL boundary r=%0d: got valid=%b res=%0d want 1 %0d", r, valid, result, exp);
        end
        ready = 1'b1;
      end
      next_cycle();
    end
    ready = 1'b0;
  endtask

  task automatic test_boundary();
    boundary_run(4, 16'd1);
    boundary_run(5, 16'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    start        = 1'b0;
    gate_len     = 16'd0;
    ev_in        = 1'b0;
    ready        = 1'b0;
    test_reset();
    test_basic_count();
    test_reset_mid_count();
    test_saturation();
    test_zero_gate();
    test_backpressure();
    test_boundary();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
